// File: rtl/dsd_tick_timer_pkg.sv
// Shared definitions for the frame-tick countdown timer: register map,
// CTRL field layout and FSM state encoding.
package dsd_tick_timer_pkg;

   localparam int unsigned BUS_DW = 32;
   localparam int unsigned ADR_W  = 3;

   // Register indices on adr_i
   localparam logic [ADR_W-1:0] REG_CTRL   = 3'd0;
   localparam logic [ADR_W-1:0] REG_RELOAD = 3'd1;
   localparam logic [ADR_W-1:0] REG_COUNT  = 3'd2;
   localparam logic [ADR_W-1:0] REG_STATUS = 3'd3;
   localparam logic [ADR_W-1:0] REG_FRAMES = 3'd4;

   // CTRL bit positions
   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_AUTO = 1;
   localparam int unsigned CTRL_IE   = 2;
   localparam int unsigned CTRL_W    = 3;

   // STATUS bit positions
   localparam int unsigned STAT_PEND = 0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Packed so that en lands on bit0, auto_rl on bit1, ie on bit2
   typedef struct packed {
      logic ie;
      logic auto_rl;
      logic en;
   } ctrl_t;

   // Extract the CTRL fields from a bus write word
   function automatic ctrl_t to_ctrl(input logic [BUS_DW-1:0] d);
      return ctrl_t'(d[CTRL_W-1:0]);
   endfunction

endpackage

// File: rtl/dsd_tick_timer_if.sv
// Wishbone-style slave bus bundle for the tick timer.
//   cyc_i/stb_i/we_i/adr_i/dat_i : master -> slave request
//   dat_o/ack_o                  : slave -> master response (registered)
interface dsd_tick_timer_if;
   import dsd_tick_timer_pkg::*;

   logic              cyc_i;
   logic              stb_i;
   logic              we_i;
   logic [ADR_W-1:0]  adr_i;
   logic [BUS_DW-1:0] dat_i;
   logic [BUS_DW-1:0] dat_o;
   logic              ack_o;

   modport slave (
      input  cyc_i, stb_i, we_i, adr_i, dat_i,
      output dat_o, ack_o
   );

   modport master (
      output cyc_i, stb_i, we_i, adr_i, dat_i,
      input  dat_o, ack_o
   );

endinterface

// File: rtl/dsd_edge_det.sv
// Registered rising-edge detector for a same-domain pulse.
//   clk_i, rst_ni : clock, async active-low reset
//   i_sig         : level input
//   o_rise_c      : combinational, high in the first cycle i_sig is high
module dsd_edge_det (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic i_sig,
   output logic o_rise_c
);

   logic r_sig_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_sig_q <= 1'b0;
      else         r_sig_q <= i_sig;
   end

   // r_sig_q resets low, so a level already high at release counts as an edge
   assign o_rise_c = i_sig & ~r_sig_q;

endmodule

// File: rtl/dsd_tick_timer.sv
// Countdown timer clocked by the 30 Hz frame tick, with free-running frame
// counter, one-shot / auto-reload expiry and a PEND/IE interrupt.
//   clk_i, rst_ni : clock, async active-low reset
//   tick_i        : frame-tick pulse (any width, same clock domain)
//   bus           : Wishbone-style slave port (dat_o/ack_o registered)
//   irq_o         : registered interrupt request, PEND & IE
module dsd_tick_timer
   import dsd_tick_timer_pkg::*;
#(
   parameter int unsigned TMR_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  tick_i,
   dsd_tick_timer_if.slave       bus,
   output logic                  irq_o
);

   logic              w_tick_re;
   logic              w_cs;
   logic              w_wr;
   logic              w_ctrl_wr;
   logic              w_reload_wr;
   logic              w_count_wr;
   logic              w_status_wr;
   logic              w_frames_wr;
   logic              w_start;
   logic              w_tick_run;
   logic              w_expire;
   logic              w_unused_dat;
   ctrl_t             w_wr_ctrl;
   state_e            w_state_nxt;
   logic [BUS_DW-1:0] w_rdata;

   state_e            r_state;
   ctrl_t             r_ctrl;
   logic [TMR_W-1:0]  r_reload;
   logic [TMR_W-1:0]  r_count;
   logic [BUS_DW-1:0] r_frames;
   logic              r_pend;

   dsd_edge_det u_tick_edge (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .i_sig    (tick_i),
      .o_rise_c (w_tick_re)
   );

   // Bus decode: a held strobe writes only on its first cycle
   assign w_cs        = bus.cyc_i & bus.stb_i;
   assign w_wr        = w_cs & bus.we_i & ~bus.ack_o;
   assign w_wr_ctrl   = to_ctrl(bus.dat_i);
   assign w_ctrl_wr   = w_wr & (bus.adr_i == REG_CTRL);
   assign w_reload_wr = w_wr & (bus.adr_i == REG_RELOAD);
   assign w_count_wr  = w_wr & (bus.adr_i == REG_COUNT);
   assign w_status_wr = w_wr & (bus.adr_i == REG_STATUS);
   assign w_frames_wr = w_wr & (bus.adr_i == REG_FRAMES);
   assign w_unused_dat = ^bus.dat_i;

   // Enabling from IDLE/DONE with an empty count picks up RELOAD
   assign w_start    = w_ctrl_wr & w_wr_ctrl.en & (r_state != RUN);
   // A direct COUNT write swallows the tick's countdown action
   assign w_tick_run = w_tick_re & (r_state == RUN) & ~w_count_wr;
   assign w_expire   = w_tick_run & (r_count <= TMR_W'(1));

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // FSM next state; a CTRL write overrides a concurrent one-shot expiry
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_ctrl_wr && w_wr_ctrl.en) w_state_nxt = RUN;
         end
         RUN: begin
            if (w_ctrl_wr)                           w_state_nxt = w_wr_ctrl.en ? RUN : IDLE;
            else if (w_expire && !r_ctrl.auto_rl)    w_state_nxt = DONE;
         end
         DONE: begin
            if (w_ctrl_wr) w_state_nxt = w_wr_ctrl.en ? RUN : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Register file, countdown and frame counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ctrl   <= '0;
         r_reload <= '0;
         r_count  <= '0;
         r_frames <= '0;
         r_pend   <= 1'b0;
         irq_o    <= 1'b0;
      end else begin
         if (w_ctrl_wr)                          r_ctrl    <= w_wr_ctrl;
         else if (w_expire && !r_ctrl.auto_rl)   r_ctrl.en <= 1'b0;

         if (w_reload_wr) r_reload <= bus.dat_i[TMR_W-1:0];

         if (w_count_wr)                   r_count <= bus.dat_i[TMR_W-1:0];
         else if (w_start && r_count == '0) r_count <= r_reload;
         else if (w_expire)                r_count <= r_ctrl.auto_rl ? r_reload : '0;
         else if (w_tick_run)              r_count <= r_count - TMR_W'(1);

         // Expiry set wins over a same-cycle software clear
         if (w_expire)                                     r_pend <= 1'b1;
         else if (w_status_wr && bus.dat_i[STAT_PEND])     r_pend <= 1'b0;

         if (w_frames_wr)    r_frames <= '0;
         else if (w_tick_re) r_frames <= r_frames + BUS_DW'(1);

         irq_o <= r_pend & r_ctrl.ie;
      end
   end

   // Read mux
   always_comb begin
      w_rdata = '0;
      case (bus.adr_i)
         REG_CTRL:   w_rdata = BUS_DW'(r_ctrl);
         REG_RELOAD: w_rdata = BUS_DW'(r_reload);
         REG_COUNT:  w_rdata = BUS_DW'(r_count);
         REG_STATUS: w_rdata = BUS_DW'({r_state, r_pend});
         REG_FRAMES: w_rdata = r_frames;
         default:    w_rdata = '0;
      endcase
   end

   // Bus response: ack follows cs by one cycle, data zero outside ack
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.ack_o <= 1'b0;
         bus.dat_o <= '0;
      end else begin
         bus.ack_o <= w_cs;
         bus.dat_o <= w_cs ? w_rdata : '0;
      end
   end

endmodule

// File: tb/tb_dsd_tick_timer.sv
// Self-checking bench for dsd_tick_timer: directed scenarios plus a random
// op mix, checked against a register-level behavioural model.
module tb_dsd_tick_timer;
   import dsd_tick_timer_pkg::*;

   localparam int unsigned TMR_W = 16;
   localparam logic [31:0] MASK  = 32'h0000_FFFF;

   logic clk;
   logic rst_ni;
   logic tick_i;
   logic irq_o;

   dsd_tick_timer_if bus ();

   dsd_tick_timer #(.TMR_W(TMR_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .tick_i (tick_i),
      .bus    (bus.slave),
      .irq_o  (irq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total;
   int bad;

   // Behavioural model: 0=IDLE 1=RUN 2=DONE
   logic        m_en, m_auto, m_ie, m_pend;
   logic [31:0] m_reload, m_count, m_frames;
   int          m_state;

   function automatic void m_reset();
      m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0;
      m_reload = 0; m_count = 0; m_frames = 0; m_state = 0;
   endfunction

   function automatic void m_write(input logic [2:0] adr, input logic [31:0] d);
      case (adr)
         3'd0: begin
            m_en = d[0]; m_auto = d[1]; m_ie = d[2];
            if (d[0]) begin
               if (m_state != 1) begin
                  m_state = 1;
                  if (m_count == 0) m_count = m_reload;
               end
            end else m_state = 0;
         end
         3'd1: m_reload = d & MASK;
         3'd2: m_count  = d & MASK;
         3'd3: if (d[0]) m_pend = 0;
         3'd4: m_frames = 0;
         default: ;
      endcase
   endfunction

   function automatic void m_tick();
      m_frames = m_frames + 1;
      if (m_state == 1) begin
         if (m_count <= 1) begin
            m_pend = 1;
            if (m_auto) m_count = m_reload;
            else begin
               m_count = 0; m_en = 0; m_state = 2;
            end
         end else m_count = m_count - 1;
      end
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] adr);
      case (adr)
         3'd0: return {29'b0, m_ie, m_auto, m_en};
         3'd1: return m_reload;
         3'd2: return m_count;
         3'd3: return {29'b0, 2'(m_state), m_pend};
         3'd4: return m_frames;
         default: return 32'h0;
      endcase
   endfunction

   // Bus/tick drivers; each enters and leaves 1 time unit after a rising edge
   task automatic bus_write(input logic [2:0] adr, input logic [31:0] d);
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = adr; bus.dat_i = d;
      @(posedge clk); #1;
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
      @(posedge clk); #1;
      m_write(adr, d);
   endtask

   task automatic bus_read(input logic [2:0] adr, output logic [31:0] d);
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = adr;
      @(posedge clk); #1;
      d = bus.dat_o;
      bus.cyc_i = 0; bus.stb_i = 0;
      @(posedge clk); #1;
   endtask

   task automatic pulse(input int w);
      tick_i = 1;
      repeat (w) begin @(posedge clk); #1; end
      tick_i = 0;
      repeat (3) begin @(posedge clk); #1; end
      m_tick();
   endtask

   task automatic test_reset();
      logic [31:0] d;
      bus_write(REG_RELOAD, 32'd3);
      bus_write(REG_CTRL, 32'b111);
      repeat (4) pulse(2);
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = REG_CTRL;
      @(posedge clk); #1;
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL reset_pre_irq got=%b exp=1", irq_o); end
      total++; if (bus.ack_o !== 1'b1) begin bad++; $display("FAIL reset_pre_ack got=%b exp=1", bus.ack_o); end
      #2 rst_ni = 0;
      #1;
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.ack_o); end
      total++; if (bus.dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", bus.dat_o); end
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
      bus.cyc_i = 0; bus.stb_i = 0;
      repeat (2) @(posedge clk);
      #1 rst_ni = 1;
      m_reset();
      bus_read(REG_STATUS, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h exp=0", d); end
      bus_read(REG_COUNT, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", d); end
   endtask

   task automatic test_wide_tick();
      logic [31:0] d;
      bus_write(REG_CTRL, 32'h0);
      bus_write(REG_COUNT, 32'd9);
      bus_write(REG_FRAMES, 32'h0);
      repeat (5) pulse(29);
      bus_read(REG_FRAMES, d);
      total++; if (d !== 32'd5) begin bad++; $display("FAIL wide_frames got=%0d exp=5", d); end
      bus_read(REG_COUNT, d);
      total++; if (d !== 32'd9) begin bad++; $display("FAIL wide_count got=%0d exp=9", d); end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      bus_write(REG_STATUS, 32'h1);
      bus_write(REG_COUNT, 32'h0);
      bus_write(REG_RELOAD, 32'd3);
      bus_write(REG_CTRL, 32'b101);
      pulse(3);
      pulse(4);
      tick_i = 1;
      @(posedge clk); #1;
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL oneshot_irq_n1 got=%b exp=0", irq_o); end
      tick_i = 0;
      @(posedge clk); #1;
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL oneshot_irq_n2 got=%b exp=1", irq_o); end
      repeat (2) begin @(posedge clk); #1; end
      m_tick();
      bus_read(REG_STATUS, d);
      total++; if (d !== 32'h5) begin bad++; $display("FAIL oneshot_status got=%h exp=5", d); end
      bus_read(REG_CTRL, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=4", d); end
      bus_read(REG_COUNT, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL oneshot_count got=%h exp=0", d); end
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = REG_STATUS; bus.dat_i = 32'h1;
      @(posedge clk); #1;
      total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL clr_irq_m1 got=%b exp=1", irq_o); end
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
      @(posedge clk); #1;
      total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL clr_irq_m2 got=%b exp=0", irq_o); end
      m_write(REG_STATUS, 32'h1);
   endtask

   task automatic test_auto_reload();
      logic [31:0] d;
      int n_exp;
      n_exp = 0;
      bus_write(REG_RELOAD, 32'd2);
      bus_write(REG_CTRL, 32'b111);
      for (int i = 0; i < 6; i++) begin
         pulse($urandom_range(1, 6));
         bus_read(REG_COUNT, d);
         total++; if (d !== m_read(REG_COUNT)) begin bad++; $display("FAIL auto_count[%0d] got=%0d exp=%0d", i, d, m_read(REG_COUNT)); end
         bus_read(REG_STATUS, d);
         total++; if (d !== m_read(REG_STATUS)) begin bad++; $display("FAIL auto_status[%0d] got=%h exp=%h", i, d, m_read(REG_STATUS)); end
         if (d[0]) begin
            n_exp++;
            bus_write(REG_STATUS, 32'h1);
         end
      end
      total++; if (n_exp !== 3) begin bad++; $display("FAIL auto_expiries got=%0d exp=3", n_exp); end
   endtask

   task automatic test_collisions();
      logic [31:0] d;
      bus_write(REG_CTRL, 32'h0);
      bus_write(REG_STATUS, 32'h1);
      bus_write(REG_RELOAD, 32'd4);
      bus_write(REG_COUNT, 32'd1);
      bus_write(REG_CTRL, 32'b011);
      // STATUS clear against expiry
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = REG_STATUS; bus.dat_i = 32'h1;
      tick_i = 1;
      @(posedge clk); #1;
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; tick_i = 0;
      repeat (2) begin @(posedge clk); #1; end
      m_write(REG_STATUS, 32'h1); m_tick();
      bus_read(REG_STATUS, d);
      total++; if (d !== 32'h3) begin bad++; $display("FAIL col_pend got=%h exp=3", d); end
      bus_read(REG_COUNT, d);
      total++; if (d !== 32'd4) begin bad++; $display("FAIL col_pend_count got=%0d exp=4", d); end
      // COUNT write against tick
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = REG_COUNT; bus.dat_i = 32'd7;
      tick_i = 1;
      @(posedge clk); #1;
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; tick_i = 0;
      repeat (2) begin @(posedge clk); #1; end
      m_frames = m_frames + 1; m_count = 7;
      bus_read(REG_COUNT, d);
      total++; if (d !== 32'd7) begin bad++; $display("FAIL col_count got=%0d exp=7", d); end
      // FRAMES clear against tick
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = REG_FRAMES; bus.dat_i = 32'hDEAD_BEEF;
      tick_i = 1;
      @(posedge clk); #1;
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; tick_i = 0;
      repeat (2) begin @(posedge clk); #1; end
      m_tick(); m_write(REG_FRAMES, 32'h0);
      bus_read(REG_FRAMES, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL col_frames got=%0d exp=0", d); end
      bus_read(REG_COUNT, d);
      total++; if (d !== 32'd6) begin bad++; $display("FAIL col_frames_count got=%0d exp=6", d); end
   endtask

   task automatic test_bus_handshake();
      logic [31:0] d;
      bus_write(REG_CTRL, 32'h0);
      bus_write(REG_COUNT, 32'h0);
      bus_write(REG_RELOAD, 32'd20);
      bus_write(REG_CTRL, 32'b001);
      // cycle 1: cs rises with a COUNT write held for three cycles
      bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 1; bus.adr_i = REG_COUNT; bus.dat_i = 32'd5;
      @(posedge clk); #1;
      total++; if (bus.ack_o !== 1'b1) begin bad++; $display("FAIL hs_ack_c2 got=%b exp=1", bus.ack_o); end
      tick_i = 1;
      @(posedge clk); #1;
      total++; if (bus.ack_o !== 1'b1) begin bad++; $display("FAIL hs_ack_c3 got=%b exp=1", bus.ack_o); end
      tick_i = 0;
      @(posedge clk); #1;
      total++; if (bus.ack_o !== 1'b1) begin bad++; $display("FAIL hs_ack_c4 got=%b exp=1", bus.ack_o); end
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
      @(posedge clk); #1;
      total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL hs_ack_c5 got=%b exp=0", bus.ack_o); end
      total++; if (bus.dat_o !== 32'h0) begin bad++; $display("FAIL hs_dat_idle got=%h exp=0", bus.dat_o); end
      m_write(REG_COUNT, 32'd5); m_tick();
      bus_read(REG_COUNT, d);
      total++; if (d !== 32'd4) begin bad++; $display("FAIL hs_single_write got=%0d exp=4", d); end
      bus_write(3'd6, 32'hFFFF_FFFF);
      bus_read(3'd6, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL hs_unused_adr got=%h exp=0", d); end
   endtask

   task automatic test_random();
      logic [31:0] d;
      logic [2:0]  adr;
      int          op;
      for (int i = 0; i < 60; i++) begin
         op = int'($urandom_range(0, 2));
         if (op == 0) pulse($urandom_range(1, 6));
         else if (op == 1) begin
            adr = 3'($urandom_range(0, 7));
            if (adr == REG_RELOAD || adr == REG_COUNT) d = 32'($urandom_range(0, 5));
            else d = $urandom;
            bus_write(adr, d);
         end else begin
            adr = 3'($urandom_range(0, 7));
            bus_read(adr, d);
            total++; if (d !== m_read(adr)) begin bad++; $display("FAIL rand_read[%0d] adr=%0d got=%h exp=%h", i, adr, d, m_read(adr)); end
         end
         total++; if (irq_o !== (m_pend & m_ie)) begin bad++; $display("FAIL rand_irq[%0d] got=%b exp=%b", i, irq_o, m_pend & m_ie); end
      end
      for (int a = 0; a < 8; a++) begin
         bus_read(3'(a), d);
         total++; if (d !== m_read(3'(a))) begin bad++; $display("FAIL rand_final adr=%0d got=%h exp=%h", a, d, m_read(3'(a))); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      total = 0; bad = 0;
      rst_ni = 0; tick_i = 0;
      bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0; bus.adr_i = '0; bus.dat_i = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1 rst_ni = 1;
      test_reset();
      test_wide_tick();
      test_oneshot();
      test_auto_reload();
      test_collisions();
      test_bus_handshake();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
